// File: rtl/kypd_bpm_entry.sv
// ============================================================================
// kypd_bpm_entry : PmodKYPD scanner/debouncer with three-digit BPM entry
// Revision: 1.0
// ============================================================================
`default_nettype none

module kypd_bpm_entry #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int BPM_MIN        = 40,
  parameter int BPM_MAX        = 240,
  parameter int BPM_DEFAULT    = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] DispVal,
  output logic [3:0] DispVal2,
  output logic [3:0] DispVal3,
  output logic [9:0] bpm_value,
  output logic       bpm_load,
  output logic       entry_err
);

  localparam int                SCAN_W    = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int                DEB_W     = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_DONE  = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [9:0]        BPM_MIN_V = 10'(BPM_MIN);
  localparam logic [9:0]        BPM_MAX_V = 10'(BPM_MAX);
  localparam logic [9:0]        BPM_DEF_V = 10'(BPM_DEFAULT);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PRESSED = 1'b1} state_t;

  // Shift-add-3 conversion; valid for inputs up to 999.
  function automatic logic [11:0] to_bcd(input logic [9:0] bin);
    logic [21:0] s;
    s = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (s[13:10] >= 4'd5) s[13:10] = s[13:10] + 4'd3;
      if (s[17:14] >= 4'd5) s[17:14] = s[17:14] + 4'd3;
      if (s[21:18] >= 4'd5) s[21:18] = s[21:18] + 4'd3;
      s = s << 1;
    end
    return s[21:10];
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]        row_meta_q, row_s_q;
  logic [SCAN_W-1:0] scan_cnt_q;
  logic [1:0]        col_idx_q;
  logic [1:0]        acc_cnt_q;
  logic [3:0]        acc_code_q;

  logic [1:0] w_lows, w_row_idx, w_merged_cnt;
  logic [2:0] w_sum;
  logic [3:0] w_merged_code;
  logic       w_sample, w_frame_done, w_single;

  assign col = ~(4'b0001 << col_idx_q);

  always_comb begin
    w_lows    = 2'd0;
    w_row_idx = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s_q[r]) begin
        if (w_lows != 2'd2) w_lows = w_lows + 2'd1;
        w_row_idx = 2'(r);
      end
    end
  end

  // Low-row count across the frame saturates at 2: anything above one key is MULTI.
  assign w_sum         = {1'b0, acc_cnt_q} + {1'b0, w_lows};
  assign w_merged_cnt  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_merged_code = (acc_cnt_q == 2'd0 && w_lows != 2'd0) ? key_map(w_row_idx, col_idx_q)
                                                               : acc_code_q;
  assign w_sample      = (scan_cnt_q == SCAN_LAST);
  assign w_frame_done  = w_sample && (col_idx_q == 2'd3);
  assign w_single      = (w_merged_cnt == 2'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
      scan_cnt_q <= '0;
      col_idx_q  <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'h0;
    end else begin
      row_meta_q <= row;
      row_s_q    <= row_meta_q;
      if (w_sample) begin
        scan_cnt_q <= '0;
        col_idx_q  <= col_idx_q + 2'd1;
        acc_cnt_q  <= w_frame_done ? 2'd0 : w_merged_cnt;
        acc_code_q <= w_frame_done ? 4'h0 : w_merged_code;
      end else begin
        scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
      end
    end
  end

  state_t           state_q, state_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d, w_cnt_inc;
  logic [3:0]       cand_q, cand_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    cand_d      = cand_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    w_cnt_inc   = deb_cnt_q + DEB_W'(1);
    if (w_frame_done) begin
      case (state_q)
        ST_IDLE: begin
          if (w_single) begin
            if (!(w_merged_code == cand_q && deb_cnt_q != '0)) w_cnt_inc = DEB_W'(1);
            cand_d = w_merged_code;
            if (w_cnt_inc == DEB_DONE) begin
              state_d     = ST_PRESSED;
              deb_cnt_d   = '0;
              key_valid_d = 1'b1;
              key_code_d  = w_merged_code;
            end else begin
              deb_cnt_d = w_cnt_inc;
            end
          end else begin
            deb_cnt_d = '0;
          end
        end
        default: begin
          // While held, only a run of empty/multi frames counts; any single key restarts it.
          if (w_single) begin
            deb_cnt_d = '0;
          end else if (w_cnt_inc == DEB_DONE) begin
            state_d   = ST_IDLE;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = w_cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      deb_cnt_q   <= '0;
      cand_q      <= 4'h0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  logic [3:0]  hund_q, tens_q, ones_q, hund_d, tens_d, ones_d;
  logic [9:0]  bpm_q, bpm_d;
  logic        load_q, load_d, err_q, err_d;
  logic [9:0]  w_entry_v;
  logic [11:0] w_bpm_bcd;

  assign w_entry_v = 10'd100 * {6'd0, hund_q} + 10'd10 * {6'd0, tens_q} + {6'd0, ones_q};
  assign w_bpm_bcd = to_bcd(bpm_q);

  always_comb begin
    hund_d = hund_q;
    tens_d = tens_q;
    ones_d = ones_q;
    bpm_d  = bpm_q;
    load_d = 1'b0;
    err_d  = 1'b0;
    if (key_valid_q) begin
      if (key_code_q <= 4'd9) begin
        hund_d = tens_q;
        tens_d = ones_q;
        ones_d = key_code_q;
      end else if (key_code_q == 4'hC) begin
        hund_d = 4'd0;
        tens_d = 4'd0;
        ones_d = 4'd0;
      end else if (key_code_q == 4'hA) begin
        if (w_entry_v >= BPM_MIN_V && w_entry_v <= BPM_MAX_V) begin
          bpm_d  = w_entry_v;
          load_d = 1'b1;
        end else begin
          err_d                  = 1'b1;
          {hund_d, tens_d, ones_d} = w_bpm_bcd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {hund_q, tens_q, ones_q} <= to_bcd(BPM_DEF_V);
      bpm_q                    <= BPM_DEF_V;
      load_q                   <= 1'b0;
      err_q                    <= 1'b0;
    end else begin
      hund_q <= hund_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      bpm_q  <= bpm_d;
      load_q <= load_d;
      err_q  <= err_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign DispVal   = hund_q;
  assign DispVal2  = tens_q;
  assign DispVal3  = ones_q;
  assign bpm_value = bpm_q;
  assign bpm_load  = load_q;
  assign entry_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_kypd_bpm_entry.sv
// ============================================================================
// tb_kypd_bpm_entry : keypad-model bench with frame-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_kypd_bpm_entry;

  localparam int SCAN  = 8;
  localparam int DEB   = 2;
  localparam int FRAME = 4 * SCAN;
  localparam int BMIN  = 40;
  localparam int BMAX  = 240;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row, col;
  logic       key_valid, bpm_load, entry_err;
  logic [3:0] key_code, DispVal, DispVal2, DispVal3;
  logic [9:0] bpm_value;

  always #5 clk = ~clk;

  kypd_bpm_entry #(
    .SCAN_CYCLES(SCAN), .DEBOUNCE_SCANS(DEB),
    .BPM_MIN(BMIN), .BPM_MAX(BMAX), .BPM_DEFAULT(120)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_valid(key_valid), .key_code(key_code),
    .DispVal(DispVal), .DispVal2(DispVal2), .DispVal3(DispVal3),
    .bpm_value(bpm_value), .bpm_load(bpm_load), .entry_err(entry_err)
  );

  // Physical keypad: bit k of keys = key with hex code k held down.
  logic [15:0] keys = 16'h0;
  int layout [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[layout[r][c]] && !col[c]) row[r] = 1'b0;
  end

  int checks = 0, errors = 0;
  int kv_seen = 0, load_seen = 0, err_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level debounce model (main process) and pending accepted key.
  int pend_key = -1;
  int pressed = 0, cand = -1, dcnt = 0;

  task automatic model_frame(input logic [15:0] m);
    int n;
    int res;
    n   = $countones(m);
    res = (n == 0) ? -1 : -2;
    if (n == 1) for (int i = 0; i < 16; i++) if (m[i]) res = i;
    if (pressed == 0) begin
      if (res >= 0) begin
        if (res == cand) dcnt++;
        else begin cand = res; dcnt = 1; end
        if (dcnt >= DEB) begin pressed = 1; dcnt = 0; cand = -1; pend_key = res; end
      end else begin
        dcnt = 0; cand = -1;
      end
    end else begin
      if (res < 0) begin
        dcnt++;
        if (dcnt >= DEB) begin pressed = 0; dcnt = 0; end
      end else begin
        dcnt = 0;
      end
    end
  endtask

  // Entry model (compare process): digits/BPM follow each accepted key one cycle later.
  int m_h = 1, m_t = 2, m_o = 0, m_bpm = 120, m_code = 0, apply_key = -1, cyc = 0;

  initial begin
    int exp_load, exp_err, v;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cyc = 0; m_h = 1; m_t = 2; m_o = 0; m_bpm = 120; m_code = 0; apply_key = -1;
        chk("rst_col", int'(col), 14);
        chk("rst_key_valid", int'(key_valid), 0);
        chk("rst_bpm_load", int'(bpm_load), 0);
        chk("rst_entry_err", int'(entry_err), 0);
        chk("rst_key_code", int'(key_code), 0);
        chk("rst_digits", int'({DispVal, DispVal2, DispVal3}), 'h120);
        chk("rst_bpm", int'(bpm_value), 120);
      end else begin
        cyc++;
        exp_load = 0;
        exp_err  = 0;
        if (apply_key >= 0) begin
          if (apply_key <= 9) begin
            m_h = m_t; m_t = m_o; m_o = apply_key;
          end else if (apply_key == 12) begin
            m_h = 0; m_t = 0; m_o = 0;
          end else if (apply_key == 10) begin
            v = 100 * m_h + 10 * m_t + m_o;
            if (v >= BMIN && v <= BMAX) begin
              m_bpm = v; exp_load = 1;
            end else begin
              exp_err = 1;
              m_h = m_bpm / 100; m_t = (m_bpm / 10) % 10; m_o = m_bpm % 10;
            end
          end
          apply_key = -1;
        end
        if (key_valid) begin
          kv_seen++;
          chk("key_valid_expected", 1, int'(pend_key >= 0));
          if (pend_key >= 0) begin
            m_code = pend_key; apply_key = pend_key; pend_key = -1;
          end
        end
        if (bpm_load) load_seen++;
        if (entry_err) err_seen++;
        chk("col", int'(col), int'(~(4'b0001 << ((cyc / SCAN) % 4)) & 4'hF));
        chk("key_code", int'(key_code), m_code);
        chk("DispVal", int'(DispVal), m_h);
        chk("DispVal2", int'(DispVal2), m_t);
        chk("DispVal3", int'(DispVal3), m_o);
        chk("bpm_value", int'(bpm_value), m_bpm);
        chk("bpm_load", int'(bpm_load), exp_load);
        chk("entry_err", int'(entry_err), exp_err);
      end
    end
  end

  // Called at the negedge of the first cycle of a frame; returns at the next frame start.
  task automatic do_frame(input logic [15:0] m);
    keys = m;
    repeat (FRAME - 1) @(negedge clk);
    chk("key_valid_missing", pend_key, -1);
    pend_key = -1;
    model_frame(m);
    @(negedge clk);
  endtask

  task automatic hold(input logic [15:0] m, input int n);
    repeat (n) do_frame(m);
  endtask

  task automatic press(input int code);
    hold(16'd1 << code, DEB);
    hold(16'h0, DEB);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; keys = 16'h0;
    pend_key = -1; pressed = 0; cand = -1; dcnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int kv0, ld0, er0;
    @(negedge clk);
    do_reset();

    // 1: reset values and column walk, one idle frame written out by hand
    chk("t1_digits", int'({DispVal, DispVal2, DispVal3}), 'h120);
    chk("t1_bpm", int'(bpm_value), 120);
    chk("t1_col0", int'(col), 'b1110);
    repeat (SCAN) @(negedge clk);
    chk("t1_col1", int'(col), 'b1101);
    repeat (SCAN) @(negedge clk);
    chk("t1_col2", int'(col), 'b1011);
    repeat (SCAN) @(negedge clk);
    chk("t1_col3", int'(col), 'b0111);
    repeat (SCAN - 1) @(negedge clk);
    model_frame(16'h0);
    @(negedge clk);
    chk("t1_col_wrap", int'(col), 'b1110);

    // 2: hold 5 for five frames
    kv0 = kv_seen;
    hold(16'd1 << 5, 5);
    hold(16'h0, DEB);
    chk("t2_kv_count", kv_seen - kv0, 1);
    chk("t2_key_code", int'(key_code), 5);
    chk("t2_digits", int'({DispVal, DispVal2, DispVal3}), 'h205);

    // 3: bounce on 7, then a stable press
    kv0 = kv_seen;
    do_frame(16'd1 << 7);
    do_frame(16'h0);
    do_frame(16'd1 << 7);
    chk("t3_bounce_kv", kv_seen - kv0, 0);
    hold(16'd1 << 7, 2);
    hold(16'h0, DEB);
    chk("t3_kv_count", kv_seen - kv0, 1);
    chk("t3_key_code", int'(key_code), 7);

    // 4: commit 090
    ld0 = load_seen;
    press(0); press(9); press(0); press(10);
    chk("t4_digits", int'({DispVal, DispVal2, DispVal3}), 'h090);
    chk("t4_bpm", int'(bpm_value), 90);
    chk("t4_load_count", load_seen - ld0, 1);

    // 5: commit 300 is out of range
    ld0 = load_seen; er0 = err_seen;
    press(3); press(0); press(0); press(10);
    chk("t5_err_count", err_seen - er0, 1);
    chk("t5_load_count", load_seen - ld0, 0);
    chk("t5_digits", int'({DispVal, DispVal2, DispVal3}), 'h090);
    chk("t5_bpm", int'(bpm_value), 90);

    // 6: two keys together, clear, then reset in the middle of a debounce
    kv0 = kv_seen;
    hold((16'd1 << 1) | (16'd1 << 2), 4);
    hold(16'h0, DEB);
    chk("t6_multi_kv", kv_seen - kv0, 0);
    press(12);
    chk("t6_clear", int'({DispVal, DispVal2, DispVal3}), 'h000);
    kv0 = kv_seen;
    do_frame(16'd1 << 9);
    repeat (12) @(negedge clk);
    do_reset();
    chk("t6_rst_digits", int'({DispVal, DispVal2, DispVal3}), 'h120);
    chk("t6_rst_bpm", int'(bpm_value), 120);
    hold(16'h0, DEB);
    chk("t6_rst_kv", kv_seen - kv0, 0);

    // Randomized key traffic checked cycle by cycle against the models
    for (int it = 0; it < 90; it++) begin
      int sel, pick, k, k2;
      sel  = $urandom_range(0, 9);
      pick = $urandom_range(0, 19);
      if (pick <= 9) k = pick;
      else if (pick <= 12) k = 10;
      else if (pick == 13) k = 12;
      else k = $urandom_range(0, 15);
      k2 = (k + $urandom_range(1, 15)) % 16;
      if (sel <= 6) begin
        hold(16'd1 << k, $urandom_range(1, 3));
        hold(16'h0, $urandom_range(1, 3));
      end else if (sel == 7) begin
        hold((16'd1 << k) | (16'd1 << k2), $urandom_range(1, 3));
        hold(16'h0, 2);
      end else if (sel == 8) begin
        hold(16'd1 << k, 2);
        hold(16'd1 << k2, 2);
        hold(16'h0, 2);
      end else begin
        do_frame(16'h0);
      end
    end
    hold(16'h0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
